// File: rtl/conv_window_stream.sv
// Streaming KxK window generator: KSIZE-1 rotating line buffers feed a shift-in window register,
// emitting one window per strided output position with valid/ready backpressure.
module conv_window_stream #(
   parameter int WIDTH    = 8,
   parameter int ADDR_BIT = 5,
   parameter int KSIZE    = 3,
   parameter int ROW_BIT  = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic [ADDR_BIT:0]              row_len_i,
   input  logic [ROW_BIT-1:0]             num_rows_i,
   input  logic [2:0]                     stride_i,
   input  logic [WIDTH-1:0]               in_data_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   output logic [KSIZE*KSIZE*WIDTH-1:0]   win_data_o,
   output logic                           win_valid_o,
   input  logic                           win_ready_i,
   output logic                           busy_o,
   output logic                           frame_done_o,
   output logic                           cfg_err_o
);

   localparam int NBUF  = KSIZE - 1;
   localparam int DEPTH = 2 ** ADDR_BIT;
   localparam int SEL_W = (NBUF > 1) ? $clog2(NBUF) : 1;
   localparam int WIN_W = KSIZE * KSIZE * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [ADDR_BIT:0]    row_len_q;
   logic [ROW_BIT-1:0]   num_rows_q;
   logic [2:0]           stride_q;
   logic [ADDR_BIT-1:0]  col_q;
   logic [ROW_BIT-1:0]   row_q;
   logic [2:0]           col_ph_q, row_ph_q;
   logic [SEL_W-1:0]     wr_sel_q;
   logic [WIN_W-1:0]     win_q, win_shift;
   logic                 win_valid_q, cfg_err_q;

   logic cfg_legal, accept, last_col, last_row, col_ok, row_ok, emit, start_ok;

   assign cfg_legal = (row_len_i >= (ADDR_BIT+1)'(KSIZE)) && (row_len_i <= (ADDR_BIT+1)'(DEPTH)) &&
                      (num_rows_i >= ROW_BIT'(KSIZE)) && (stride_i <= 3'd4);
   assign start_ok  = (state_q == S_IDLE) && start_i && cfg_legal;
   assign in_ready_o = (state_q == S_LOAD) && (!win_valid_q || win_ready_i);
   assign accept    = in_valid_i && in_ready_o;
   assign last_col  = ({1'b0, col_q} == row_len_q - 1'b1);
   assign last_row  = (row_q == num_rows_q - 1'b1);
   assign col_ok    = ({1'b0, col_q} >= (ADDR_BIT+1)'(KSIZE-1));
   assign row_ok    = (row_q >= ROW_BIT'(KSIZE-1));
   assign emit      = accept && col_ok && row_ok && (col_ph_q == 3'd0) && (row_ph_q == 3'd0);

   // Row r is stored in buffer r % NBUF, so the slot being overwritten holds the oldest row.
   logic [WIDTH-1:0] lb_rd [NBUF];
   for (genvar gi = 0; gi < NBUF; gi++) begin : g_lb
      logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk_i) begin
         if (accept && (wr_sel_q == SEL_W'(gi))) begin
            mem[col_q] <= in_data_i;
         end
      end
      assign lb_rd[gi] = mem[col_q];
   end

   logic [WIDTH-1:0] col_pix [KSIZE];
   logic [SEL_W:0]   sel;
   always_comb begin
      sel = '0;
      for (int r = 0; r < NBUF; r++) begin
         sel = {1'b0, wr_sel_q} + (SEL_W+1)'(r);
         if (sel >= (SEL_W+1)'(NBUF)) begin
            sel = sel - (SEL_W+1)'(NBUF);
         end
         col_pix[r] = lb_rd[sel[SEL_W-1:0]];
      end
      col_pix[KSIZE-1] = in_data_i;
   end

   always_comb begin
      win_shift = '0;
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE; c++) begin
            if (c < KSIZE - 1) begin
               win_shift[((r*KSIZE+c)*WIDTH) +: WIDTH] = win_q[((r*KSIZE+c+1)*WIDTH) +: WIDTH];
            end else begin
               win_shift[((r*KSIZE+c)*WIDTH) +: WIDTH] = col_pix[r];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_ok) state_d = S_LOAD;
         S_LOAD:  if (accept && last_col && last_row) state_d = S_DRAIN;
         S_DRAIN: if (!win_valid_q || win_ready_i) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         row_len_q   <= '0;
         num_rows_q  <= '0;
         stride_q    <= 3'd1;
         col_q       <= '0;
         row_q       <= '0;
         col_ph_q    <= '0;
         row_ph_q    <= '0;
         wr_sel_q    <= '0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= (state_q == S_IDLE) && start_i && !cfg_legal;
         if (start_ok) begin
            row_len_q  <= row_len_i;
            num_rows_q <= num_rows_i;
            stride_q   <= (stride_i == 3'd0) ? 3'd1 : stride_i;
            col_q      <= '0;
            row_q      <= '0;
            col_ph_q   <= '0;
            row_ph_q   <= '0;
            wr_sel_q   <= '0;
         end
         if (accept) begin
            win_q <= win_shift;
            if (last_col) begin
               col_q    <= '0;
               col_ph_q <= '0;
               row_q    <= row_q + 1'b1;
               wr_sel_q <= (wr_sel_q == SEL_W'(NBUF-1)) ? '0 : wr_sel_q + 1'b1;
               if (row_ok) begin
                  row_ph_q <= (row_ph_q == stride_q - 3'd1) ? 3'd0 : row_ph_q + 3'd1;
               end
            end else begin
               col_q <= col_q + 1'b1;
               if (col_ok) begin
                  col_ph_q <= (col_ph_q == stride_q - 3'd1) ? 3'd0 : col_ph_q + 3'd1;
               end
            end
         end
         // A completing accept can coincide with the consumer taking the previous window.
         if (emit) begin
            win_valid_q <= 1'b1;
         end else if (win_ready_i) begin
            win_valid_q <= 1'b0;
         end
      end
   end

   assign win_data_o   = win_q;
   assign win_valid_o  = win_valid_q;
   assign busy_o       = (state_q == S_LOAD) || (state_q == S_DRAIN);
   assign frame_done_o = (state_q == S_DONE);
   assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_conv_window_stream.sv
// Self-checking bench for conv_window_stream: table of frame configurations checked against a
// window-enumeration model, plus hand sequences for config errors and mid-frame reset.
module tb_conv_window_stream;

   localparam int W = 8, AB = 5, K = 3, RB = 8, WW = K*K*W, MAXPIX = 2048;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [AB:0]     row_len;
   logic [RB-1:0]   num_rows;
   logic [2:0]      stride;
   logic [W-1:0]    in_data;
   logic            in_valid, in_ready;
   logic [WW-1:0]   win_data;
   logic            win_valid, win_ready;
   logic            busy, frame_done, cfg_err;

   always #5 clk = ~clk;

   conv_window_stream #(.WIDTH(W), .ADDR_BIT(AB), .KSIZE(K), .ROW_BIT(RB)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .row_len_i(row_len), .num_rows_i(num_rows),
      .stride_i(stride), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .win_data_o(win_data), .win_valid_o(win_valid), .win_ready_i(win_ready), .busy_o(busy),
      .frame_done_o(frame_done), .cfg_err_o(cfg_err));

   typedef struct {
      int rl; int nr; int s; int vprob; int rmode; int dmode; int exp_win;
   } vec_t;

   vec_t          tbl [9];
   int            n_tests = 0, n_fail = 0;
   logic [W-1:0]  pix [MAXPIX];
   logic [WW-1:0] exp_q [$];
   int            exp_end_q [$];

   task automatic check(string name, logic [WW-1:0] act, logic [WW-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Enumerate every strided window position directly from the frame geometry.
   task automatic build_model(int rl, int nr, int s);
      int se;
      logic [WW-1:0] w;
      se = (s == 0) ? 1 : s;
      exp_q.delete();
      exp_end_q.delete();
      for (int r0 = 0; r0 <= nr - K; r0 += se) begin
         for (int c0 = 0; c0 <= rl - K; c0 += se) begin
            w = '0;
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++)
                  w[((r*K+c)*W) +: W] = pix[(r0+r)*rl + c0 + c];
            exp_q.push_back(w);
            exp_end_q.push_back((r0+K-1)*rl + c0 + K - 1);
         end
      end
   endtask

   task automatic fill_pix(int total, int dmode);
      for (int i = 0; i < total; i++) pix[i] = (dmode == 0) ? W'(i) : W'($urandom);
   endtask

   task automatic run_frame(vec_t v, string tag);
      int total, k, pidx, fd, cyc, extra, stall_cnt, end0;
      bit pend_lat, prev_stall;
      logic [WW-1:0] prev_data;
      total = v.rl * v.nr;
      build_model(v.rl, v.nr, v.s);
      end0 = exp_end_q[0];
      k = 0; pidx = 0; fd = 0; cyc = 0; extra = 0; stall_cnt = 0;
      pend_lat = 0; prev_stall = 0; prev_data = '0;
      @(negedge clk);
      start = 1'b1; row_len = (AB+1)'(v.rl); num_rows = RB'(v.nr); stride = 3'(v.s);
      in_valid = 1'b0; win_ready = 1'b0;
      while (cyc < 5000 && extra < 3) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         row_len = (AB+1)'($urandom); num_rows = RB'($urandom); stride = 3'($urandom);
         in_valid = (pidx < total) && ($urandom_range(1, 100) <= v.vprob);
         in_data  = in_valid ? pix[pidx] : W'($urandom);
         case (v.rmode)
            0: win_ready = 1'b1;
            1: win_ready = (stall_cnt >= 10);
            default: win_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (pend_lat) begin
            check({tag, " latency"}, WW'(win_valid), WW'(1));
            pend_lat = 0;
         end
         if (prev_stall) begin
            check({tag, " hold_valid"}, WW'(win_valid), WW'(1));
            check({tag, " hold_data"}, win_data, prev_data);
         end
         if (win_valid && !win_ready) check({tag, " stall_in_ready"}, WW'(in_ready), WW'(0));
         prev_stall = win_valid && !win_ready;
         prev_data  = win_data;
         if (v.rmode == 1 && win_valid && stall_cnt < 10) stall_cnt++;
         if (win_valid && win_ready) begin
            if (k < exp_q.size()) check({tag, " window"}, win_data, exp_q[k]);
            else check({tag, " extra_window"}, WW'(k), WW'(exp_q.size()));
            k++;
         end
         if (in_valid && in_ready) begin
            if (pidx == end0) pend_lat = 1;
            pidx++;
         end
         if (frame_done) fd++;
         if (fd > 0) extra++;
      end
      if (cyc >= 5000) check({tag, " timeout"}, WW'(cyc), WW'(0));
      check({tag, " win_count"}, WW'(k), WW'(v.exp_win));
      check({tag, " frame_done_count"}, WW'(fd), WW'(1));
      check({tag, " pixels"}, WW'(pidx), WW'(total));
      check({tag, " busy_after"}, WW'(busy), WW'(0));
      $display("[TB] frame %s rl=%0d nr=%0d s=%0d: %0d windows, %0d pixels, %0d cycles",
               tag, v.rl, v.nr, v.s, k, pidx, cyc);
   endtask

   task automatic cfg_err_case(int rl, int nr, int s, string tag);
      @(negedge clk);
      start = 1'b1; row_len = (AB+1)'(rl); num_rows = RB'(nr); stride = 3'(s);
      in_valid = 1'b1; win_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check({tag, " cfg_err"}, WW'(cfg_err), WW'(1));
      check({tag, " busy"}, WW'(busy), WW'(0));
      check({tag, " in_ready"}, WW'(in_ready), WW'(0));
      @(negedge clk);
      #1;
      check({tag, " cfg_err_pulse"}, WW'(cfg_err), WW'(0));
      check({tag, " still_idle"}, WW'(busy), WW'(0));
      in_valid = 1'b0;
      $display("[TB] cfg %s rl=%0d nr=%0d s=%0d rejected", tag, rl, nr, s);
   endtask

   task automatic abort_case();
      int pidx, cyc;
      fill_pix(64, 0);
      @(negedge clk);
      start = 1'b1; row_len = 7'd8; num_rows = 8'd8; stride = 3'd1;
      pidx = 0; cyc = 0;
      while (pidx < 30 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0; in_valid = 1'b1; in_data = pix[pidx]; win_ready = 1'b1;
         #1;
         if (in_ready) pidx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort win_valid", WW'(win_valid), WW'(0));
      check("abort busy", WW'(busy), WW'(0));
      check("abort in_ready", WW'(in_ready), WW'(0));
      check("abort win_data", win_data, WW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("abort no_frame_done", WW'(frame_done), WW'(0));
         check("abort idle", WW'(busy), WW'(0));
      end
      $display("[TB] abort after %0d pixels", pidx);
   endtask

   initial begin
      tbl[0] = '{8, 8, 2, 100, 0, 0, 9};
      tbl[1] = '{8, 8, 1, 100, 0, 0, 36};
      tbl[2] = '{8, 8, 1, 100, 1, 0, 36};
      tbl[3] = '{11, 9, 3, 50, 0, 1, 9};
      tbl[4] = '{8, 8, 0, 100, 2, 1, 36};
      tbl[5] = '{32, 4, 4, 80, 2, 1, 8};
      tbl[6] = '{3, 3, 1, 100, 0, 1, 1};
      tbl[7] = '{10, 6, 2, 70, 2, 1, 8};
      tbl[8] = '{7, 5, 4, 60, 1, 1, 2};

      rst_n = 1'b0; start = 1'b0; row_len = '0; num_rows = '0; stride = '0;
      in_data = '0; in_valid = 1'b0; win_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset win_valid", WW'(win_valid), WW'(0));
      check("reset busy", WW'(busy), WW'(0));
      check("reset in_ready", WW'(in_ready), WW'(0));
      check("reset frame_done", WW'(frame_done), WW'(0));
      check("reset cfg_err", WW'(cfg_err), WW'(0));
      check("reset win_data", win_data, WW'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 9; t++) begin
         fill_pix(tbl[t].rl * tbl[t].nr, tbl[t].dmode);
         run_frame(tbl[t], $sformatf("vec%0d", t));
      end

      cfg_err_case(2, 8, 1, "row_len_small");
      cfg_err_case(8, 8, 6, "stride6");
      cfg_err_case(33, 8, 1, "row_len_big");
      cfg_err_case(8, 2, 1, "rows_small");

      abort_case();
      fill_pix(64, 0);
      run_frame(tbl[1], "after_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
